// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Covers the FSM state encoding, funct3 size/sign codes and the alignment rule.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_REQ   = 2'd1,
        LSU_WAIT  = 2'd2,
        LSU_DRAIN = 2'd3
    } lsu_state_t;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic size_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (funct3[1:0] == 2'b01)
            mis = off[0];
        else if (funct3[1:0] == 2'b10)
            mis = (off != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: store strobe/data placement,
// misalignment detection and load byte/halfword extraction with extension.
module lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    output logic [3:0]      store_strb,
    output logic [XLEN-1:0] store_data,
    output logic            misaligned,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign misaligned = size_misaligned(funct3, off);

    always_comb begin
        store_strb = 4'b1111;
        store_data = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                store_strb = 4'b0001 << off;
                store_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                store_strb = off[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
            end
            default: begin
                store_strb = 4'b1111;
                store_data = wdata;
            end
        endcase
    end

    // Extraction uses the offset/funct3 captured at issue, not the live MEM inputs.
    always_comb begin
        lane_b    = rdata[8*ld_off +: 8];
        lane_h    = ld_off[1] ? rdata[31:16] : rdata[15:0];
        ld_result = rdata;
        unique case (ld_funct3)
            FUNCT3_LB:  ld_result = XLEN'($signed(lane_b));
            FUNCT3_LH:  ld_result = XLEN'($signed(lane_h));
            FUNCT3_LBU: ld_result = {{(XLEN-8){1'b0}}, lane_b};
            FUNCT3_LHU: ld_result = {{(XLEN-16){1'b0}}, lane_h};
            default:    ld_result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns one load/store into a single data-bus
// transaction, stalls the pipeline via mem_req_o/mem_done_o and drains killed responses.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mem_valid_i,
    input  logic            mem_is_load_i,
    input  logic            mem_is_store_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_wdata_i,
    input  logic            mem_trap_valid_i,
    input  logic            kill_i,
    output logic            mem_req_o,
    output logic            mem_done_o,
    output logic [XLEN-1:0] mem_rdata_o,
    output logic            misaligned_load_o,
    output logic            misaligned_store_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_wstrb_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    lsu_state_t      state;
    logic            killed;

    logic [1:0]      cap_off;
    logic [2:0]      cap_funct3;
    logic            cap_load;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [3:0]      req_strb;
    logic [XLEN-1:0] req_wdata;

    logic [3:0]      store_strb;
    logic [XLEN-1:0] store_data;
    logic            misaligned;
    logic [XLEN-1:0] ld_result;
    logic            access;
    logic            live;
    logic            issue;
    logic [XLEN-1:0] cur_addr;
    logic [3:0]      cur_strb;
    logic [XLEN-1:0] cur_wdata;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (mem_funct3_i),
        .off        (mem_addr_i[1:0]),
        .wdata      (mem_wdata_i),
        .store_strb (store_strb),
        .store_data (store_data),
        .misaligned (misaligned),
        .ld_funct3  (cap_funct3),
        .ld_off     (cap_off),
        .rdata      (dmem_rdata_i),
        .ld_result  (ld_result)
    );

    assign misaligned_load_o  = mem_valid_i && mem_is_load_i && misaligned;
    assign misaligned_store_o = mem_valid_i && mem_is_store_i && misaligned;

    assign access = mem_valid_i && (mem_is_load_i || mem_is_store_i) && !mem_trap_valid_i
                    && !misaligned_load_o && !misaligned_store_o;
    assign live   = access && !kill_i && !rst_i;
    assign issue  = (state == LSU_IDLE) && live;

    assign cur_addr  = {mem_addr_i[XLEN-1:2], 2'b00};
    assign cur_strb  = mem_is_store_i ? store_strb : 4'b0000;
    assign cur_wdata = mem_is_store_i ? store_data : '0;

    // A stalled access stays requested in every state; a new access behind a drain waits here.
    assign mem_req_o   = live;
    assign mem_done_o  = (state == LSU_WAIT) && dmem_rvalid_i && !kill_i && !rst_i;
    assign mem_rdata_o = (mem_done_o && cap_load) ? ld_result : '0;

    // Bus drive: live inputs on the issue cycle, registered copy while waiting for grant.
    always_comb begin
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wstrb_o = 4'b0000;
        dmem_wdata_o = '0;
        if (!rst_i) begin
            if (state == LSU_REQ) begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = req_we;
                dmem_addr_o  = req_addr;
                dmem_wstrb_o = req_strb;
                dmem_wdata_o = req_wdata;
            end else if (issue) begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = mem_is_store_i;
                dmem_addr_o  = cur_addr;
                dmem_wstrb_o = cur_strb;
                dmem_wdata_o = cur_wdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= LSU_IDLE;
            killed <= 1'b0;
        end else begin
            unique case (state)
                LSU_IDLE: begin
                    killed <= 1'b0;
                    if (issue)
                        state <= dmem_gnt_i ? LSU_WAIT : LSU_REQ;
                end
                LSU_REQ: begin
                    if (kill_i)
                        killed <= 1'b1;
                    if (dmem_gnt_i)
                        state <= (killed || kill_i) ? LSU_DRAIN : LSU_WAIT;
                end
                LSU_WAIT: begin
                    // A kill coinciding with the response needs no drain: the response is already here.
                    if (dmem_rvalid_i)
                        state <= LSU_IDLE;
                    else if (kill_i)
                        state <= LSU_DRAIN;
                end
                LSU_DRAIN: begin
                    if (dmem_rvalid_i)
                        state <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue) begin
            cap_off    <= mem_addr_i[1:0];
            cap_funct3 <= mem_funct3_i;
            cap_load   <= mem_is_load_i;
            req_we     <= mem_is_store_i;
            req_addr   <= cur_addr;
            req_strb   <= cur_strb;
            req_wdata  <= cur_wdata;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus randomized bench for mem_lsu with a behavioural bus/lane model.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_is_load, mem_is_store, mem_trap_valid, kill;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_req, mem_done, misaligned_load, misaligned_store;
    logic [31:0] mem_rdata;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_lsu #(.XLEN(32)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .mem_valid_i        (mem_valid),
        .mem_is_load_i      (mem_is_load),
        .mem_is_store_i     (mem_is_store),
        .mem_funct3_i       (mem_funct3),
        .mem_addr_i         (mem_addr),
        .mem_wdata_i        (mem_wdata),
        .mem_trap_valid_i   (mem_trap_valid),
        .kill_i             (kill),
        .mem_req_o          (mem_req),
        .mem_done_o         (mem_done),
        .mem_rdata_o        (mem_rdata),
        .misaligned_load_o  (misaligned_load),
        .misaligned_store_o (misaligned_store),
        .dmem_req_o         (dmem_req),
        .dmem_we_o          (dmem_we),
        .dmem_addr_o        (dmem_addr),
        .dmem_wstrb_o       (dmem_wstrb),
        .dmem_wdata_o       (dmem_wdata),
        .dmem_gnt_i         (dmem_gnt),
        .dmem_rvalid_i      (dmem_rvalid),
        .dmem_rdata_i       (dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: size in bytes from funct3, then plain arithmetic on lanes.
    function automatic int size_of(input logic [2:0] f3);
        int s;
        s = 4;
        if (f3[1:0] == 2'b00) s = 1;
        else if (f3[1:0] == 2'b01) s = 2;
        return s;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
        longint v, lim;
        int     sz;
        sz  = size_of(f3);
        lim = longint'(1) << (8 * sz);
        v   = (longint'(rd) >> (8 * (addr % 4))) % lim;
        if (!f3[2] && sz < 4 && v >= lim / 2) v = v - lim;
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
        int off, sz;
        off = addr % 4;
        sz  = size_of(f3);
        return 32'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz;
        sz = size_of(f3);
        if (sz == 1) return (wd % 256) * 32'h0101_0101;
        if (sz == 2) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_is_load = 1'b0; mem_is_store = 1'b0; mem_trap_valid = 1'b0;
        kill = 1'b0; mem_funct3 = 3'b000; mem_addr = '0; mem_wdata = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        mem_valid = 1'b1; mem_is_load = ld; mem_is_store = !ld;
        mem_funct3 = f3; mem_addr = addr; mem_wdata = wd;
    endtask

    // One complete access: grant after gdelay extra cycles, response the cycle after grant.
    task automatic run_op(input string tag, input logic ld, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int gdelay,
                          input logic [31:0] rd);
        logic [31:0] e_strb, e_data;
        e_strb = ld ? 32'h0 : ref_strb(f3, addr);
        e_data = ld ? 32'h0 : ref_wdata(f3, wd);
        present(ld, f3, addr, wd);
        for (int c = 0; c <= gdelay; c++) begin
            dmem_gnt = (c == gdelay);
            @(negedge clk);
            check({tag, "_mem_req"}, 32'(mem_req), 32'd1);
            check({tag, "_dmem_req"}, 32'(dmem_req), 32'd1);
            check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
            check({tag, "_we"}, 32'(dmem_we), 32'(!ld));
            check({tag, "_strb"}, 32'(dmem_wstrb), e_strb);
            check({tag, "_wdata"}, dmem_wdata, e_data);
            check({tag, "_nodone"}, 32'(mem_done), 32'd0);
            next_cycle();
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd;
        @(negedge clk);
        check({tag, "_wait_dmem_req"}, 32'(dmem_req), 32'd0);
        check({tag, "_done"}, 32'(mem_done), 32'd1);
        if (ld) check({tag, "_rdata"}, mem_rdata, ref_load(f3, addr, rd));
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check({tag, "_after_done"}, 32'(mem_done), 32'd0);
        check({tag, "_after_rdata"}, mem_rdata, 32'd0);
        next_cycle();
    endtask

    initial begin
        logic [2:0]  ld_f3s [5];
        logic [2:0]  st_f3s [3];
        logic        r_ld;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        ld_f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3s = '{3'b000, 3'b001, 3'b010};

        idle_inputs();
        rst = 1'b1;
        present(1'b1, 3'b010, 32'h100, 32'h0);
        dmem_gnt = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_done", 32'(mem_done), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_strb", 32'(dmem_wstrb), 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        next_cycle();

        run_op("lw",  1'b1, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
        run_op("lb",  1'b1, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_FFFF);
        run_op("lbu", 1'b1, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_FFFF);
        run_op("lhu", 1'b1, 3'b101, 32'h102, 32'h0, 0, 32'h8001_0000);
        run_op("sb",  1'b0, 3'b000, 32'h201, 32'h1234_56AB, 0, 32'h0);
        run_op("sh",  1'b0, 3'b001, 32'h202, 32'h1234_56AB, 0, 32'h0);
        run_op("sw_slow", 1'b0, 3'b010, 32'h208, 32'hCAFE_F00D, 3, 32'h0);
        run_op("lh_slow", 1'b1, 3'b001, 32'h20E, 32'h0, 3, 32'h8765_4321);

        present(1'b1, 3'b010, 32'h102, 32'h0);
        @(negedge clk);
        check("mis_ld_flag", 32'(misaligned_load), 32'd1);
        check("mis_ld_dmem_req", 32'(dmem_req), 32'd0);
        check("mis_ld_mem_req", 32'(mem_req), 32'd0);
        next_cycle();
        mem_valid = 1'b0;
        @(negedge clk);
        check("mis_ld_invalid", 32'(misaligned_load), 32'd0);
        next_cycle();
        present(1'b0, 3'b001, 32'h203, 32'h0);
        @(negedge clk);
        check("mis_st_flag", 32'(misaligned_store), 32'd1);
        check("mis_st_dmem_req", 32'(dmem_req), 32'd0);
        next_cycle();
        idle_inputs();

        // Kill while waiting for the response, then a new load behind the drain.
        present(1'b1, 3'b010, 32'h100, 32'h0);
        dmem_gnt = 1'b1;
        next_cycle();
        dmem_gnt = 1'b0; kill = 1'b1;
        @(negedge clk);
        check("kw_kill_mem_req", 32'(mem_req), 32'd0);
        check("kw_kill_done", 32'(mem_done), 32'd0);
        next_cycle();
        kill = 1'b0;
        present(1'b1, 3'b010, 32'h300, 32'h0);
        @(negedge clk);
        check("kw_new_mem_req", 32'(mem_req), 32'd1);
        check("kw_drain_dmem_req", 32'(dmem_req), 32'd0);
        next_cycle();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        check("kw_drain_done", 32'(mem_done), 32'd0);
        check("kw_drain_dmem_req2", 32'(dmem_req), 32'd0);
        next_cycle();
        dmem_rvalid = 1'b0; dmem_gnt = 1'b1;
        @(negedge clk);
        check("kw_reissue_req", 32'(dmem_req), 32'd1);
        check("kw_reissue_addr", dmem_addr, 32'h300);
        check("kw_reissue_done", 32'(mem_done), 32'd0);
        next_cycle();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1122_3344;
        @(negedge clk);
        check("kw_new_done", 32'(mem_done), 32'd1);
        check("kw_new_rdata", mem_rdata, 32'h1122_3344);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Kill while the request is still waiting for grant.
        present(1'b1, 3'b010, 32'h400, 32'h0);
        next_cycle();
        kill = 1'b1;
        @(negedge clk);
        check("kr_held_req", 32'(dmem_req), 32'd1);
        check("kr_held_addr", dmem_addr, 32'h400);
        next_cycle();
        idle_inputs();
        dmem_gnt = 1'b1;
        @(negedge clk);
        check("kr_gnt_req", 32'(dmem_req), 32'd1);
        next_cycle();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1;
        @(negedge clk);
        check("kr_drain_done", 32'(mem_done), 32'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("kr_idle_req", 32'(dmem_req), 32'd0);
        next_cycle();

        for (int i = 0; i < 30; i++) begin
            r_ld = 1'($urandom_range(0, 1));
            r_f3 = r_ld ? ld_f3s[$urandom_range(0, 4)] : st_f3s[$urandom_range(0, 2)];
            r_addr = $urandom;
            if (size_of(r_f3) == 2) r_addr[0] = 1'b0;
            if (size_of(r_f3) == 4) r_addr[1:0] = 2'b00;
            run_op($sformatf("rnd%0d", i), r_ld, r_f3, r_addr, $urandom,
                   int'($urandom_range(0, 2)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
